// File: rtl/sift_win_pkg.sv
// sift_win_pkg: shared FSM state type, window size and counter width helpers for the 3x3 scan controller
package sift_win_pkg;
    typedef enum logic [1:0] {IDLE, FILL0, FILL1, RUN} state_t;
    localparam int WIN_K = 3;
    function automatic int x_w(input int img_w);
        return $clog2(img_w);
    endfunction
    function automatic int y_w(input int img_h);
        return $clog2(img_h);
    endfunction
endpackage

// File: rtl/window3x3_scan_ctrl_if.sv
// window3x3_scan_ctrl_if: pixel strobe in, line-buffer enables and window info out
// WIN3X3_CNT_EN adds the per-frame window count signal.
interface window3x3_scan_ctrl_if #(parameter int IMG_W = 512, parameter int IMG_H = 512);
    localparam int X_W = sift_win_pkg::x_w(IMG_W);
    localparam int Y_W = sift_win_pkg::y_w(IMG_H);
    logic sof;
    logic pix_valid;
    logic lb0_wr_en;
    logic lb0_rd_en;
    logic lb1_wr_en;
    logic lb1_rd_en;
    logic sr_shift;
    logic lb_flush;
    logic win_valid;
    logic [X_W-1:0] win_x;
    logic [Y_W-1:0] win_y;
    logic eol;
    logic eof;
    logic err_abort;
`ifdef WIN3X3_CNT_EN
    logic [$clog2(IMG_W*IMG_H)-1:0] win_cnt;
`endif
    modport master (
        output sof, pix_valid,
        input lb0_wr_en, lb0_rd_en, lb1_wr_en, lb1_rd_en, sr_shift, lb_flush,
        input win_valid, win_x, win_y, eol, eof, err_abort
`ifdef WIN3X3_CNT_EN
        , input win_cnt
`endif
    );
    modport slave (
        input sof, pix_valid,
        output lb0_wr_en, lb0_rd_en, lb1_wr_en, lb1_rd_en, sr_shift, lb_flush,
        output win_valid, win_x, win_y, eol, eof, err_abort
`ifdef WIN3X3_CNT_EN
        , output win_cnt
`endif
    );
endinterface

// File: rtl/win_raster_cnt.sv
// win_raster_cnt: raster col/row position of the current pixel with end-of-line/frame flags
// clr forces the current position to (0,0) so the sof pixel counts from the frame origin.
module win_raster_cnt import sift_win_pkg::*; #(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int X_W = x_w(IMG_W),
    parameter int Y_W = y_w(IMG_H)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           inc,
    input  logic           clr,
    output logic [X_W-1:0] col,
    output logic [Y_W-1:0] row,
    output logic           eol,
    output logic           eof
);
    logic [X_W-1:0] col_q;
    logic [Y_W-1:0] row_q;
    always_comb begin
        col = clr ? '0 : col_q;
        row = clr ? '0 : row_q;
        eol = col == X_W'(IMG_W - 1);
        eof = eol & (row == Y_W'(IMG_H - 1));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (inc) begin
            col_q <= eol ? '0 : col + 1'b1;
            row_q <= eol ? (eof ? '0 : row + 1'b1) : row;
        end else if (clr) begin
            col_q <= '0;
            row_q <= '0;
        end
    end
endmodule

// File: rtl/window3x3_scan_ctrl.sv
// window3x3_scan_ctrl: raster sequencer for the 3x3 line-buffer window datapath
// Optional WIN3X3_CNT_EN adds a per-frame count of emitted windows.
module window3x3_scan_ctrl import sift_win_pkg::*; #(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512
) (
    input logic clk,
    input logic rst,
    window3x3_scan_ctrl_if.slave bus
);
    localparam int X_W = x_w(IMG_W);
    localparam int Y_W = y_w(IMG_H);
    state_t state, state_nx, phase;
    logic [X_W-1:0] col;
    logic [Y_W-1:0] row;
    logic row_end, frame_end, start, accept, win_due;
    assign start = bus.pix_valid & bus.sof;
    assign accept = start | (bus.pix_valid & (state != IDLE));
    win_raster_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_cnt (
        .clk(clk), .rst(rst), .inc(accept), .clr(start),
        .col(col), .row(row), .eol(row_end), .eof(frame_end)
    );
    // A sof pixel always behaves as row 0 of a new frame, whatever state we were in.
    always_comb begin
        state_nx = state;
        phase = start ? FILL0 : state;
        if (start)
            state_nx = FILL0;
        else if (accept & row_end)
            state_nx = state == FILL0 ? FILL1 : state == FILL1 ? RUN : frame_end ? IDLE : RUN;
        bus.lb0_wr_en = accept;
        bus.lb0_rd_en = accept & (phase == FILL1 | phase == RUN);
        bus.lb1_wr_en = accept & (phase == FILL1 | phase == RUN);
        bus.lb1_rd_en = accept & (phase == RUN);
        bus.sr_shift = accept;
        win_due = accept & (col >= X_W'(WIN_K - 1)) & (row >= Y_W'(WIN_K - 1));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bus.win_valid <= 1'b0;
            bus.win_x <= '0;
            bus.win_y <= '0;
            bus.eol <= 1'b0;
            bus.eof <= 1'b0;
            bus.err_abort <= 1'b0;
            bus.lb_flush <= 1'b0;
        end else begin
            state <= state_nx;
            bus.win_valid <= win_due;
            bus.win_x <= win_due ? col - 1'b1 : '0;
            bus.win_y <= win_due ? row - 1'b1 : '0;
            bus.eol <= win_due & row_end;
            bus.eof <= win_due & frame_end;
            bus.err_abort <= start & (state != IDLE);
            bus.lb_flush <= start;
        end
    end
`ifdef WIN3X3_CNT_EN
    always_ff @(posedge clk) begin
        if (rst | start)
            bus.win_cnt <= '0;
        else if (bus.win_valid)
            bus.win_cnt <= bus.win_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_window3x3_scan_ctrl.sv
// tb_window3x3_scan_ctrl: directed scoreboard bench for window3x3_scan_ctrl on an 8x6 frame
// Build with WIN3X3_CNT_EN to also check the window counter.
module tb_window3x3_scan_ctrl;
    localparam int W = 8;
    localparam int H = 6;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    window3x3_scan_ctrl_if #(.IMG_W(W), .IMG_H(H)) bus();
    window3x3_scan_ctrl #(.IMG_W(W), .IMG_H(H)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {int x; int y; logic eol; logic eof;} win_t;
    win_t q[$];
    int errors = 0, checks = 0;
    bit m_active = 0;
    int m_col = 0, m_row = 0;
    int f_wins, f_eofs, first_x, first_y, eof_x, eof_y;
    bit first_seen;
    int err_seen = 0, flush_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic s, input logic v);
        bit was_active, acc, due;
        int pc, pr;
        win_t w;
        @(negedge clk);
        bus.sof = s;
        bus.pix_valid = v;
        was_active = m_active;
        acc = v & (s | m_active);
        if (acc & s) begin
            m_col = 0;
            m_row = 0;
            m_active = 1;
        end
        pc = m_col;
        pr = m_row;
        due = acc && pc >= 2 && pr >= 2;
        if (due) q.push_back('{pc - 1, pr - 1, pc == W - 1, pc == W - 1 && pr == H - 1});
        #1;
        chk("lb0_wr_en", bus.lb0_wr_en, acc);
        chk("lb0_rd_en", bus.lb0_rd_en, acc && pr >= 1);
        chk("lb1_wr_en", bus.lb1_wr_en, acc && pr >= 1);
        chk("lb1_rd_en", bus.lb1_rd_en, acc && pr >= 2);
        chk("sr_shift", bus.sr_shift, acc);
        if (acc) begin
            if (m_col == W - 1) begin
                m_col = 0;
                if (m_row == H - 1) begin
                    m_row = 0;
                    m_active = 0;
                end else m_row++;
            end else m_col++;
        end
        @(posedge clk);
        #1;
        chk("win_valid", bus.win_valid, due);
        chk("err_abort", bus.err_abort, v & s & was_active);
        chk("lb_flush", bus.lb_flush, v & s);
        if (bus.err_abort) err_seen++;
        if (bus.lb_flush) flush_seen++;
        if (bus.win_valid) begin
            f_wins++;
            if (!first_seen) begin
                first_seen = 1;
                first_x = int'(bus.win_x);
                first_y = int'(bus.win_y);
            end
            if (bus.eof) begin
                f_eofs++;
                eof_x = int'(bus.win_x);
                eof_y = int'(bus.win_y);
            end
        end
        if (q.size() > 0) begin
            w = q.pop_front();
            if (bus.win_valid) begin
                chk("win_x", bus.win_x, w.x);
                chk("win_y", bus.win_y, w.y);
                chk("eol", bus.eol, w.eol);
                chk("eof", bus.eof, w.eof);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.sof = 1'b0;
        bus.pix_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_lb0_wr", bus.lb0_wr_en, 0);
        chk("rst_lb0_rd", bus.lb0_rd_en, 0);
        chk("rst_lb1_wr", bus.lb1_wr_en, 0);
        chk("rst_lb1_rd", bus.lb1_rd_en, 0);
        chk("rst_sr_shift", bus.sr_shift, 0);
        chk("rst_win_valid", bus.win_valid, 0);
        chk("rst_win_x", bus.win_x, 0);
        chk("rst_win_y", bus.win_y, 0);
        chk("rst_eol", bus.eol, 0);
        chk("rst_eof", bus.eof, 0);
        chk("rst_err_abort", bus.err_abort, 0);
        chk("rst_lb_flush", bus.lb_flush, 0);
`ifdef WIN3X3_CNT_EN
        chk("rst_win_cnt", bus.win_cnt, 0);
`endif
        rst = 1'b0;
        m_active = 0;
        m_col = 0;
        m_row = 0;
        q.delete();
    endtask

    task automatic frame(input bit gaps);
        step(1'b1, 1'b1);
        f_wins = 0;
        f_eofs = 0;
        first_seen = 0;
        first_x = -1;
        first_y = -1;
        eof_x = -1;
        eof_y = -1;
`ifdef WIN3X3_CNT_EN
        chk("win_cnt_clr", bus.win_cnt, 0);
`endif
        for (int i = 1; i < W * H; i++) begin
            if (gaps) step(1'b0, 1'b0);
            step(1'b0, 1'b1);
        end
        step(1'b0, 1'b0);
        chk("frame_wins", f_wins, 24);
        chk("frame_eofs", f_eofs, 1);
        chk("first_x", first_x, 1);
        chk("first_y", first_y, 1);
        chk("eof_x", eof_x, 6);
        chk("eof_y", eof_y, 4);
`ifdef WIN3X3_CNT_EN
        chk("win_cnt", bus.win_cnt, 24);
`endif
    endtask

    initial begin
        bus.sof = 1'b0;
        bus.pix_valid = 1'b0;
        do_reset();
        frame(1'b0);
        frame(1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1);
        chk("state_idle", dut.state, 0);
        err_seen = 0;
        flush_seen = 0;
        step(1'b1, 1'b1);
        for (int i = 1; i < 20; i++) step(1'b0, 1'b1);
        frame(1'b0);
        chk("abort_pulses", err_seen, 1);
        chk("flush_pulses", flush_seen, 2);
        step(1'b1, 1'b1);
        for (int i = 1; i < 30; i++) step(1'b0, 1'b1);
        do_reset();
        frame(1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
